// File: rtl/decoder_nto2n_pipe.sv
// Registered N-to-2^N one-hot decoder with valid/ready handshake and auto-scan.
// Ports: clk, rst_n (sync, active-low), mode (0 decode / 1 scan, sampled in IDLE),
//   in_valid/in_ready/sel (input handshake), out_valid/out_ready/y (one-hot output),
//   scan_wrap (pulse when scan wraps MSB->bit 0).
// Latency: sel accepted at edge t appears on y after edge t; y holds under out_ready=0.
// Optional macro DECODER_NTO2N_COUNT_EN adds clr_count input and dec_count[15:0] output
//   (saturating count of decode acceptances plus scan rotates).
module decoder_nto2n_pipe #(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    scan_wrap
`ifdef DECODER_NTO2N_COUNT_EN
  ,
  input  logic                    clr_count,
  output logic [15:0]             dec_count
`endif
);

  localparam int          OUT_W  = 1 << SEL_W;
  localparam logic [15:0] DIV_TC = 16'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [15:0]        div_q, div_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   y_rot;
  logic [OUT_W-1:0]   y_dec;

  assign out_valid = (state_q != IDLE);
  assign y         = y_q;
  assign scan_wrap = wrap_q;
  assign in_ready  = (state_q != SCAN) && (!out_valid || out_ready);

  assign y_rot = {y_q[OUT_W-2:0], y_q[OUT_W-1]};
  assign y_dec = OUT_W'(1) << sel;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        y_d = '0;
        if (mode) begin
          state_d = SCAN;
          y_d     = OUT_W'(1);
          div_d   = '0;
        end else if (in_valid) begin
          state_d = DECODE;
          y_d     = y_dec;
        end
      end
      DECODE: begin
        if (out_ready) begin
          if (in_valid) begin
            y_d = y_dec;
          end else begin
            state_d = IDLE;
            y_d     = '0;
          end
        end
      end
      SCAN: begin
        // The divider parks on terminal count until the consumer takes the word,
        // so every one-hot position is seen for at least SCAN_DIV cycles.
        if (div_q != DIV_TC) begin
          div_d = div_q + 16'd1;
        end else if (out_ready) begin
          div_d = '0;
          if (y_q[OUT_W-1]) begin
            // Exit only at the end of a full sweep; no wrap pulse on exit.
            if (!mode) begin
              state_d = IDLE;
              y_d     = '0;
            end else begin
              y_d    = y_rot;
              wrap_d = 1'b1;
            end
          end else begin
            y_d = y_rot;
          end
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      div_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      div_q   <= div_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DECODER_NTO2N_COUNT_EN
  logic [15:0] dec_count_q;
  logic        accept;
  logic        rotate;

  // In IDLE with mode=1 in_ready is high but the word is not taken.
  assign accept    = in_valid && in_ready && !((state_q == IDLE) && mode);
  assign rotate    = (state_q == SCAN) && (div_q == DIV_TC) && out_ready;
  assign dec_count = dec_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_count_q <= '0;
    end else if (clr_count) begin
      dec_count_q <= '0;
    end else if ((accept || rotate) && (dec_count_q != 16'hFFFF)) begin
      dec_count_q <= dec_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_nto2n_pipe.sv
// Bench for decoder_nto2n_pipe: directed table + hand sequences on SEL_W=2/SCAN_DIV=4
// and SEL_W=3/SCAN_DIV=1, then random stimulus against an index-based reference model.
module tb_decoder_nto2n_pipe;

  localparam int SD2 = 4;
  localparam int SD3 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, mode2, iv2, ir2, ov2, or2, wr2;
  logic [1:0] sel2;
  logic [3:0] y2;
  logic       rst3, mode3, iv3, ir3, ov3, or3, wr3;
  logic [2:0] sel3;
  logic [7:0] y3;
`ifdef DECODER_NTO2N_COUNT_EN
  logic        clr2, clr3;
  logic [15:0] cnt2, cnt3;
`endif

  decoder_nto2n_pipe #(.SEL_W(2), .SCAN_DIV(SD2)) u2 (
    .clk(clk), .rst_n(rst2), .mode(mode2), .in_valid(iv2), .in_ready(ir2), .sel(sel2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .scan_wrap(wr2)
`ifdef DECODER_NTO2N_COUNT_EN
    , .clr_count(clr2), .dec_count(cnt2)
`endif
  );

  decoder_nto2n_pipe #(.SEL_W(3), .SCAN_DIV(SD3)) u3 (
    .clk(clk), .rst_n(rst3), .mode(mode3), .in_valid(iv3), .in_ready(ir3), .sel(sel3),
    .out_valid(ov3), .out_ready(or3), .y(y3), .scan_wrap(wr3)
`ifdef DECODER_NTO2N_COUNT_EN
    , .clr_count(clr3), .dec_count(cnt3)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step2(input bit r, input bit m, input bit v, input int s, input bit o,
                       input int ey, input int ev, input int eir, input int ewr,
                       input string tag);
    rst2 = r; mode2 = m; iv2 = v; sel2 = s[1:0]; or2 = o;
    @(posedge clk); #1;
    chk({tag, " y"}, y2, ey);
    chk({tag, " out_valid"}, ov2, ev);
    chk({tag, " in_ready"}, ir2, eir);
    chk({tag, " scan_wrap"}, wr2, ewr);
  endtask

  task automatic step3(input bit r, input bit m, input bit v, input int s, input bit o,
                       input int ey, input int ev, input int eir, input int ewr,
                       input string tag);
    rst3 = r; mode3 = m; iv3 = v; sel3 = s[2:0]; or3 = o;
    @(posedge clk); #1;
    chk({tag, " y"}, y3, ey);
    chk({tag, " out_valid"}, ov3, ev);
    chk({tag, " in_ready"}, ir3, eir);
    chk({tag, " scan_wrap"}, wr3, ewr);
  endtask

  // Reference model: state as 0 idle / 1 decode / 2 scan, the active line as an index.
  typedef struct { int st; int pos; int div; bit wr; } m_t;

  function automatic m_t mstep(m_t m, bit r, bit mo, bit v, int s, bit o, int ow, int sd);
    m_t n = m;
    n.wr = 1'b0;
    if (!r) begin
      n.st = 0; n.pos = 0; n.div = 0;
      return n;
    end
    case (m.st)
      0: if (mo) begin n.st = 2; n.pos = 0; n.div = 0; end
         else if (v) begin n.st = 1; n.pos = s; end
      1: if (o) begin
           if (v) n.pos = s;
           else begin n.st = 0; n.pos = 0; end
         end
      default: begin
        if (m.div < sd - 1) n.div = m.div + 1;
        else if (o) begin
          n.div = 0;
          if (m.pos == ow - 1) begin
            if (!mo) begin n.st = 0; n.pos = 0; end
            else begin n.pos = 0; n.wr = 1'b1; end
          end else n.pos = m.pos + 1;
        end
      end
    endcase
    return n;
  endfunction

  function automatic int m_y(m_t m);
    return (m.st != 0) ? (1 << m.pos) : 0;
  endfunction

  function automatic int m_ir(m_t m, bit o);
    return ((m.st != 2) && (m.st == 0 || o)) ? 1 : 0;
  endfunction

  typedef struct { bit r; bit m; bit v; int s; bit o; int ey; int ev; int eir; int ewr; } vec_t;
  vec_t tbl[$];

  initial begin
    m_t    m2, m3;
    bit    r, mo2, mo3, v2, v3, o2, o3;
    int    s2, s3;

    rst2 = 0; mode2 = 0; iv2 = 0; sel2 = '0; or2 = 1;
    rst3 = 0; mode3 = 0; iv3 = 0; sel3 = '0; or3 = 1;
`ifdef DECODER_NTO2N_COUNT_EN
    clr2 = 0; clr3 = 0;
`endif

    // Reset, sweep, backpressure, reset with a held word.
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 1, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 1, k, 1, 1 << k, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 2, 1, 4, 1, 1, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 0, 1, 3, 0, 4, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 3, 1, 8, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 1, 1, 2, 1, 1, 0});
    tbl.push_back('{1, 0, 1, 2, 0, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 2, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 1, 0});

    for (int i = 0; i < tbl.size(); i++)
      step2(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].s, tbl[i].o,
            tbl[i].ey, tbl[i].ev, tbl[i].eir, tbl[i].ewr, $sformatf("vec%0d", i));

    // Scan: each position held 4 cycles, one wrap pulse, run until y=0100 at terminal count.
    for (int k = 0; k < 28; k++)
      step2(1, 1, 0, 0, 1, 1 << ((k / 4) % 4), 1, 0, (k == 16) ? 1 : 0, $sformatf("scan%0d", k));
    // Stall at terminal count with mode dropped: y frozen.
    for (int k = 0; k < 3; k++) step2(1, 0, 0, 0, 0, 4, 1, 0, 0, $sformatf("stall%0d", k));
    // Release: finish the sweep on 1000, then IDLE with no wrap.
    for (int k = 0; k < 4; k++) step2(1, 0, 0, 0, 1, 8, 1, 0, 0, $sformatf("finish%0d", k));
    step2(1, 0, 0, 0, 1, 0, 0, 1, 0, "scan_exit");
    // Reset in the middle of a scan.
    step2(1, 1, 0, 0, 1, 1, 1, 0, 0, "rscan0");
    step2(1, 1, 0, 0, 1, 1, 1, 0, 0, "rscan1");
    step2(0, 1, 0, 0, 1, 0, 0, 1, 0, "rscan_rst");
    step2(1, 0, 0, 0, 1, 0, 0, 1, 0, "rscan_idle");

    // SEL_W=3 sweep, then a SCAN_DIV=1 scan with wrap and exit.
    step3(0, 0, 0, 0, 1, 0, 0, 1, 0, "w3_rst");
    for (int k = 0; k < 8; k++) step3(1, 0, 1, k, 1, 1 << k, 1, 1, 0, $sformatf("w3_sweep%0d", k));
    step3(1, 0, 0, 0, 1, 0, 0, 1, 0, "w3_idle");
    for (int k = 0; k < 9; k++)
      step3(1, 1, 0, 0, 1, 1 << (k % 8), 1, 0, (k == 8) ? 1 : 0, $sformatf("w3_scan%0d", k));
    for (int k = 9; k < 16; k++)
      step3(1, 0, 0, 0, 1, 1 << (k % 8), 1, 0, 0, $sformatf("w3_scan%0d", k));
    step3(1, 0, 0, 0, 1, 0, 0, 1, 0, "w3_exit");

`ifdef DECODER_NTO2N_COUNT_EN
    step2(0, 0, 0, 0, 1, 0, 0, 1, 0, "cnt_rst");
    chk("cnt_reset", cnt2, 0);
    for (int i = 0; i < 10; i++) step2(1, 0, 1, i % 4, 1, 1 << (i % 4), 1, 1, 0, "cnt_acc");
    chk("cnt_ten", cnt2, 10);
    clr2 = 1;
    step2(1, 0, 1, 0, 1, 1, 1, 1, 0, "cnt_clr");
    clr2 = 0;
    chk("cnt_clr_prio", cnt2, 0);
    force u2.dec_count_q = 16'hFFFE;
    #1;
    release u2.dec_count_q;
    for (int i = 0; i < 3; i++) step2(1, 0, 1, i, 1, 1 << i, 1, 1, 0, "cnt_sat");
    chk("cnt_saturate", cnt2, 16'hFFFF);
`endif

    // Random phase against the reference model on both instances.
    m2 = '{0, 0, 0, 1'b0};
    m3 = '{0, 0, 0, 1'b0};
    mo2 = 0; mo3 = 0;
    for (int i = 0; i < 1500; i++) begin
      r = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) mo2 = ~mo2;
      if ($urandom_range(0, 15) == 0) mo3 = ~mo3;
      v2 = ($urandom_range(0, 3) != 0); v3 = ($urandom_range(0, 3) != 0);
      o2 = ($urandom_range(0, 3) != 0); o3 = ($urandom_range(0, 3) != 0);
      s2 = $urandom_range(0, 3);        s3 = $urandom_range(0, 7);
      rst2 = r; mode2 = mo2; iv2 = v2; sel2 = s2[1:0]; or2 = o2;
      rst3 = r; mode3 = mo3; iv3 = v3; sel3 = s3[2:0]; or3 = o3;
      #1;
      chk("rnd2 in_ready", ir2, m_ir(m2, o2));
      chk("rnd3 in_ready", ir3, m_ir(m3, o3));
      @(posedge clk);
      m2 = mstep(m2, r, mo2, v2, s2, o2, 4, SD2);
      m3 = mstep(m3, r, mo3, v3, s3, o3, 8, SD3);
      #1;
      chk("rnd2 y", y2, m_y(m2));
      chk("rnd2 out_valid", ov2, (m2.st != 0) ? 1 : 0);
      chk("rnd2 scan_wrap", wr2, m2.wr);
      chk("rnd3 y", y3, m_y(m3));
      chk("rnd3 out_valid", ov3, (m3.st != 0) ? 1 : 0);
      chk("rnd3 scan_wrap", wr3, m3.wr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_pipe.md
Name: decoder_nto2n_pipe

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; next generation of the team's 2-to-4 decoders.
- Adds a valid/ready input and output handshake, a one-stage output register and a hold buffer.
- Adds an auto-scan mode that steps the one-hot output through all lines. Used for chip-select, row-strobe and mux-select generation.

Parameters:
- SEL_W, 2, width of the select code. OUT_W = 2**SEL_W is a derived localparam, not overridable.
- SCAN_DIV, 4, clocks each one-hot position is held in scan mode. Legal range is 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = decode, 1 = auto-scan. Sampled only in IDLE.
- in_valid  input  1  sel is valid (decode mode).
- in_ready  output  1  block can accept sel this cycle.
- sel  input  SEL_W  select code; bit SEL_W-1 is MSB, matching {a,b} ordering of the 2-to-4 decoders.
- out_valid  output  1  y holds a valid one-hot word.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  OUT_W  one-hot output; y[k]=1 for code k; all-zero when not valid.
- scan_wrap  output  1  one-cycle pulse when scan moves from y[OUT_W-1] to y[0].

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, y=0, out_valid=0, scan_wrap=0, scan counters=0. Reset wins over every other event, including mid-transfer and mid-scan. Any held word is discarded.
- in_ready = (state!=SCAN) && (!out_valid || out_ready). This is combinational, with no dependence on in_valid.
- States:
  - IDLE: out_valid=0, y=0.
    - mode=0 and in_valid: register y=1<<sel and out_valid=1 next cycle, go to DECODE.
    - mode=1: go to SCAN with y=1 (bit 0) and out_valid=1 next cycle. in_valid is ignored.
  - DECODE: out_valid=1 and y is stable until out_ready.
    - out_ready && in_valid: load the new word next cycle, stay in DECODE (back-to-back, full throughput).
    - out_ready && !in_valid: go to IDLE, clearing y and out_valid.
    - !out_ready: hold y; sel is ignored (in_ready=0).
  - SCAN: out_valid=1 and y is one-hot.
    - A divider counter counts 0..SCAN_DIV-1. On the terminal count, y rotates left by 1 (MSB wraps to bit 0) and the divider clears.
    - The rotate takes effect only if out_ready=1 on the terminal-count cycle. Otherwise the divider holds at terminal count until out_ready.
    - scan_wrap=1 for exactly the cycle y transitions from bit OUT_W-1 to bit 0.
    - Exit: mode=0 sampled while y[OUT_W-1]=1 and a rotate occurs. Next state is IDLE instead of wrapping, so a scan is never truncated and scan_wrap does not pulse on exit.
- Latency: sel accepted at edge t gives y valid after edge t (1 cycle).
- Invariant: popcount(y) is 1 when out_valid=1 and 0 when out_valid=0.
- SEL_W=1 must work: OUT_W=2, and scan alternates between the two lines.

Optional Feature:
- Macro: DECODER_NTO2N_COUNT_EN.
- Defined:
  - Adds output port dec_count [15:0].
  - dec_count increments on every input acceptance (in_valid && in_ready) in decode mode and every scan rotate. It saturates at 16'hFFFF.
  - Reset value is 0.
  - Adds input clr_count; clr_count=1 zeroes dec_count next cycle, with priority over increment.
- Not defined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Reset/sweep: SEL_W=2, hold rst_n=0 for 3 cycles, then release. Send sel=0,1,2,3 with out_ready=1 → y=0001,0010,0100,1000 one cycle after each acceptance. out_valid stays high with no gaps, and in_ready stays 1.
- Backpressure: sel=2 accepted, out_ready=0 for 5 cycles while sel=3 is presented → y holds 0100 and in_ready=0. Raise out_ready → y=1000 next cycle.
- Scan: mode=1, SCAN_DIV=4, out_ready=1 → y steps 0001→0010→0100→1000→0001, every 4 cycles. scan_wrap pulses once, on the 1000→0001 edge.
- Scan stall and exit: drop out_ready at a terminal count → y frozen. Set mode=0 while y=0100 → scan completes to 1000, then IDLE with y=0000 and no scan_wrap pulse.
- Reset mid-operation: assert rst_n=0 during DECODE with a held word, and again in SCAN → next edge y=0, out_valid=0, state IDLE. SEL_W=3 repeat of the sweep gives the 8 one-hot codes.
- With DECODER_NTO2N_COUNT_EN defined: 10 accepted sel values give dec_count=10. clr_count together with an acceptance gives 0. Force the counter to 16'hFFFE and accept 3 more → 16'hFFFF.
